// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//
// Raster timing generator for 640x480@60 VGA (defaults), clocked by the
// 25.2 MHz pixel clock from the PLL and gated by the PLL lock indicator.
//
// Ports:
//   refclk       in   pixel clock (PLL outclk_0)
//   rst_n        in   asynchronous active-low reset
//   locked       in   PLL lock, asynchronous to refclk
//   hsync        out  horizontal sync, asserted level = SYNC_POL
//   vsync        out  vertical sync, asserted level = SYNC_POL
//   de           out  active-video enable
//   x, y         out  pixel column/row, valid when de=1 (0 otherwise)
//   line_start   out  one-cycle pulse at h=0 of every line
//   frame_start  out  one-cycle pulse at h=0, v=0
//   running      out  timing generator active
//
// Latency: locked rise -> first frame_start is 4 cycles
// (2 synchronizer + 1 state + 1 output register). Every output comes from
// the same register stage, so all outputs are mutually aligned.
// ---------------------------------------------------------------------------
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0,
  parameter int CW       = 10
) (
  input  logic          refclk,
  input  logic          rst_n,
  input  logic          locked,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          line_start,
  output logic          frame_start,
  output logic          running
);

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW    = $clog2(H_TOT);
  localparam int VW    = $clog2(V_TOT);

  // Decode boundaries sized to the counters so every compare is unsigned
  // and width-matched.
  localparam logic [HW-1:0] H_LAST     = HW'(H_TOT - 1);
  localparam logic [HW-1:0] H_DE_END   = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SYNC_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SYNC_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST     = VW'(V_TOT - 1);
  localparam logic [VW-1:0] V_DE_END   = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SYNC_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SYNC_END = VW'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t        state, state_next;
  logic          lk_s1, lk_s2;
  logic          enable;
  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;

  // -------------------------------------------------------------------------
  // Lock synchronizer: locked comes straight from the PLL with no timing
  // relationship to refclk, so it crosses through two flops before use.
  // -------------------------------------------------------------------------
  // NOTE: every clocked register uses non-blocking assignment so all flops
  // sample the pre-edge values; blocking here would collapse the two
  // synchronizer stages into one.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      lk_s1 <= 1'b0;
      lk_s2 <= 1'b0;
    end else begin
      lk_s1 <= locked;
      lk_s2 <= lk_s1;
    end
  end

  assign enable = lk_s2;

  // -------------------------------------------------------------------------
  // State machine: IDLE while unlocked, RUN while locked. Loss of lock
  // drops straight back to IDLE, even mid-frame.
  // -------------------------------------------------------------------------
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: state_next gets its default before the case so every path assigns
  // it; a missing default would infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (enable)  state_next = RUN;
      RUN:     if (!enable) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Raster counters. They only advance while already in RUN and still
  // enabled, so the first RUN cycle always sees 0,0 and the cycle that
  // leaves RUN clears them for the next relock.
  // -------------------------------------------------------------------------
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (state == RUN && enable) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        // The v wrap happens on the same edge as the h wrap of the last line.
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end
    end else begin
      h_cnt <= '0;
      v_cnt <= '0;
    end
  end

  // -------------------------------------------------------------------------
  // Output decode: one register stage behind the counters. Everything is
  // qualified by RUN so IDLE reproduces the reset values exactly.
  // -------------------------------------------------------------------------
  logic is_run;
  logic de_next;
  logic h_in_sync;
  logic v_in_sync;
  logic h_zero;

  assign is_run    = (state == RUN);
  assign de_next   = is_run && (h_cnt < H_DE_END) && (v_cnt < V_DE_END);
  assign h_in_sync = (h_cnt >= H_SYNC_BEG) && (h_cnt < H_SYNC_END);
  assign v_in_sync = (v_cnt >= V_SYNC_BEG) && (v_cnt < V_SYNC_END);
  assign h_zero    = (h_cnt == '0);

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      running     <= 1'b0;
      de          <= 1'b0;
      x           <= '0;
      y           <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
    end else begin
      running     <= is_run;
      de          <= de_next;
      x           <= de_next ? CW'(h_cnt) : '0;
      y           <= de_next ? CW'(v_cnt) : '0;
      line_start  <= is_run && h_zero;
      frame_start <= is_run && h_zero && (v_cnt == '0);
      hsync       <= (is_run && h_in_sync) ? SYNC_POL : ~SYNC_POL;
      vsync       <= (is_run && v_in_sync) ? SYNC_POL : ~SYNC_POL;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen
//
// Two instances share clock, reset and lock: a reduced-geometry instance
// (32x19 total, 16x12 visible) so whole frames fit in a short run, and a
// default 640x480 instance for line-level timing. A raster model derives
// expected outputs from how long lock has been held, three edges back
// (two synchronizer edges plus one state edge), and is compared against both
// instances on every falling edge. Directed checks with literal values pin
// the model's latency and geometry.
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;

  localparam int CW = 10;

  // Small geometry
  localparam int S_HA = 16, S_HFP = 4, S_HS = 6, S_HBP = 6;
  localparam int S_VA = 12, S_VFP = 2, S_VS = 2, S_VBP = 3;
  // Default geometry
  localparam int D_HA = 640, D_HFP = 16, D_HS = 96, D_HBP = 48;
  localparam int D_VA = 480, D_VFP = 10, D_VS = 2,  D_VBP = 33;

  typedef struct packed {
    logic          running;
    logic          hsync;
    logic          vsync;
    logic          de;
    logic          line_start;
    logic          frame_start;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
  } obs_t;

  logic clk;
  logic rst_n;
  logic locked;

  logic          hs_s, vs_s, de_s, ls_s, fs_s, run_s;
  logic [CW-1:0] x_s, y_s;
  logic          hs_d, vs_d, de_d, ls_d, fs_d, run_d;
  logic [CW-1:0] x_d, y_d;

  int n_cmp = 0;
  int n_bad = 0;

  vga_timing_gen #(
    .H_ACTIVE(S_HA), .H_FP(S_HFP), .H_SYNC(S_HS), .H_BP(S_HBP),
    .V_ACTIVE(S_VA), .V_FP(S_VFP), .V_SYNC(S_VS), .V_BP(S_VBP),
    .SYNC_POL(1'b0), .CW(CW)
  ) dut_s (
    .refclk(clk), .rst_n(rst_n), .locked(locked),
    .hsync(hs_s), .vsync(vs_s), .de(de_s), .x(x_s), .y(y_s),
    .line_start(ls_s), .frame_start(fs_s), .running(run_s)
  );

  vga_timing_gen dut_d (
    .refclk(clk), .rst_n(rst_n), .locked(locked),
    .hsync(hs_d), .vsync(vs_d), .de(de_d), .x(x_d), .y(y_d),
    .line_start(ls_d), .frame_start(fs_d), .running(run_d)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  // -------------------------------------------------------------------------
  // Model: streak = number of consecutive edges at which locked was seen high.
  // Output after edge k reflects the streak as of edge k-3.
  // -------------------------------------------------------------------------
  int hist [4] = '{0, 0, 0, 0};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) hist[i] = 0;
    end else begin
      for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = locked ? hist[1] + 1 : 0;
    end
  end

  function automatic obs_t model(input int s, input int ha, input int hfp, input int hs,
                                 input int hbp, input int va, input int vfp, input int vs,
                                 input int vbp);
    obs_t o;
    int htot, vtot, p, h, v;
    o = '0;
    o.hsync = 1'b1;
    o.vsync = 1'b1;
    if (s > 0) begin
      htot = ha + hfp + hs + hbp;
      vtot = va + vfp + vs + vbp;
      p = (s - 1) % (htot * vtot);
      h = p % htot;
      v = p / htot;
      o.running     = 1'b1;
      o.de          = (h < ha) && (v < va);
      if (o.de) begin
        o.x = CW'(h);
        o.y = CW'(v);
      end
      o.hsync       = !((h >= ha + hfp) && (h < ha + hfp + hs));
      o.vsync       = !((v >= va + vfp) && (v < va + vfp + vs));
      o.line_start  = (h == 0);
      o.frame_start = (p == 0);
    end
    return o;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  obs_t obs_s, obs_d;
  assign obs_s = {run_s, hs_s, vs_s, de_s, ls_s, fs_s, x_s, y_s};
  assign obs_d = {run_d, hs_d, vs_d, de_d, ls_d, fs_d, x_d, y_d};

  always @(negedge clk) begin
    check("model_small", obs_s,
          model(hist[3], S_HA, S_HFP, S_HS, S_HBP, S_VA, S_VFP, S_VS, S_VBP));
    check("model_default", obs_d,
          model(hist[3], D_HA, D_HFP, D_HS, D_HBP, D_VA, D_VFP, D_VS, D_VBP));
  end

  // Run-time guard
  initial begin
    #1ms;
    $display("FAIL timeout: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "timeout");
  end

  // -------------------------------------------------------------------------
  // Directed stimulus
  // -------------------------------------------------------------------------
  int act;
  int de_cs, hs_cs, vs_cs, ls_cs, fs_cs, hs_first_s, fs_second_s;
  int de_cd, hs_cd, vs_cd, ls_cd, fs_cd, hs_first_d;

  initial begin
    rst_n  = 1'b0;
    locked = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Unlocked for 1000 cycles: nothing moves
    act = 0;
    repeat (1000) begin
      @(negedge clk);
      if (run_s | de_s | ls_s | fs_s | run_d | de_d | ls_d | fs_d) act++;
    end
    check("unlocked_activity", act, 0);
    check("unlocked_sync", {hs_s, vs_s, hs_d, vs_d}, 4'hF);
    check("unlocked_xy", {x_s, y_s, x_d, y_d}, '0);

    // Lock start: first frame_start 4 cycles after the rise
    locked = 1'b1;
    repeat (3) @(negedge clk);
    check("lock_no_early_start", {run_s, fs_s, fs_d}, 3'b000);
    @(negedge clk);
    check("lock_first_frame_start", {run_s, fs_s, de_s, fs_d, de_d}, 5'b11111);
    check("lock_first_xy", {x_s, y_s, x_d, y_d}, '0);

    // 800-cycle window starting at that frame_start sample
    de_cs = 0; hs_cs = 0; vs_cs = 0; ls_cs = 0; fs_cs = 0;
    de_cd = 0; hs_cd = 0; vs_cd = 0; ls_cd = 0; fs_cd = 0;
    hs_first_s = -1; hs_first_d = -1; fs_second_s = -1;
    for (int i = 0; i < 800; i++) begin
      if (i > 0) @(negedge clk);
      de_cs += int'(de_s);  hs_cs += int'(!hs_s); vs_cs += int'(!vs_s);
      ls_cs += int'(ls_s);  fs_cs += int'(fs_s);
      de_cd += int'(de_d);  hs_cd += int'(!hs_d); vs_cd += int'(!vs_d);
      ls_cd += int'(ls_d);  fs_cd += int'(fs_d);
      if (!hs_s && hs_first_s < 0) hs_first_s = i;
      if (!hs_d && hs_first_d < 0) hs_first_d = i;
      if (fs_s && i > 0 && fs_second_s < 0) fs_second_s = i;
    end
    check("small_de_count", de_cs, 288);
    check("small_hsync_count", hs_cs, 150);
    check("small_vsync_count", vs_cs, 64);
    check("small_line_starts", ls_cs, 25);
    check("small_frame_starts", fs_cs, 2);
    check("small_frame_period", fs_second_s, 608);
    check("small_hsync_first", hs_first_s, 20);
    check("default_de_count", de_cd, 640);
    check("default_hsync_count", hs_cd, 96);
    check("default_hsync_first", hs_first_d, 656);
    check("default_vsync_count", vs_cd, 0);
    check("default_line_starts", ls_cd, 1);
    check("default_frame_starts", fs_cd, 1);

    // Advance to small frame 2, line 6, pixel 10 and drop lock there
    repeat (619) @(negedge clk);
    check("mid_frame_pos", {de_s, x_s, y_s}, {1'b1, 10'd10, 10'd6});
    locked = 1'b0;
    repeat (3) @(negedge clk);
    check("loss_still_running", {run_s, run_d}, 2'b11);
    @(negedge clk);
    check("loss_idle", {run_s, de_s, hs_s, vs_s, run_d, de_d, hs_d, vs_d}, 8'b0011_0011);
    check("loss_xy", {x_s, y_s, ls_s, fs_s}, '0);

    // Relock: new frame from 0,0 led by frame_start
    repeat (10) @(negedge clk);
    locked = 1'b1;
    repeat (3) @(negedge clk);
    check("relock_no_early_start", {run_s, fs_s}, 2'b00);
    @(negedge clk);
    check("relock_frame_start", {fs_s, de_s, ls_s, fs_d}, 4'b1111);
    check("relock_xy", {x_s, y_s}, '0);

    // Async reset pulse between edges, while running
    repeat (50) @(negedge clk);
    #5 rst_n = 1'b0;
    #2;
    check("async_reset_idle", {run_s, de_s, hs_s, vs_s, ls_s, fs_s, run_d, de_d, hs_d, vs_d},
          10'b0011_00_0011);
    check("async_reset_xy", {x_s, y_s, x_d, y_d}, '0);
    #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_reset_idle", {run_s, fs_s}, 2'b00);
    @(negedge clk);
    check("post_reset_frame_start", {run_s, fs_s, x_s, y_s}, {2'b11, 20'd0});

    // One more complete small frame under the continuous compare
    repeat (700) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Consumer end of the pixel-clock PLL. Runs on the 25.2 MHz pixel clock and gates itself with the PLL lock indicator.
- Generates 640x480@60 VGA raster timing: HSYNC, VSYNC, data-enable, pixel coordinates and frame/line strobes.
- Feeds the framebuffer reader and the DAC/HDMI output stage. All outputs are registered and held idle whenever the PLL is unlocked.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_POL, 0, asserted level of hsync/vsync (0 = active-low)
- CW, 10, width of x/y counters and outputs

Ports:
- refclk  input  1  pixel clock (PLL outclk_0)
- rst_n  input  1  asynchronous active-low reset
- locked  input  1  PLL lock, asynchronous to refclk
- hsync  output  1  horizontal sync
- vsync  output  1  vertical sync
- de  output  1  active-video enable
- x  output  CW  pixel column, valid when de=1
- y  output  CW  pixel row, valid when de=1
- line_start  output  1  one-cycle pulse at h=0 of every line
- frame_start  output  1  one-cycle pulse at h=0, v=0
- running  output  1  timing generator active

Behaviour:
- Reset: one clock; rst_n is asynchronous, active-low. On reset, running=0, de=0, x=0, y=0, line_start=0, frame_start=0, and hsync=vsync=~SYNC_POL (deasserted). Sync registers clear to 0.
- Lock synchronizer:
  - locked passes through 2 flops (lk_s1, lk_s2), both reset to 0.
  - enable = lk_s2.
- Counters:
  - H_TOT = H_ACTIVE+H_FP+H_SYNC+H_BP (default 800).
  - V_TOT = V_ACTIVE+V_FP+V_SYNC+V_BP (default 525).
  - h_cnt and v_cnt are internal, each with enough bits to hold TOT-1.
  - While enable=1: h_cnt increments every cycle and wraps H_TOT-1 -> 0. v_cnt increments when h_cnt wraps, and wraps V_TOT-1 -> 0 at the h wrap of the last line.
  - While enable=0: h_cnt=v_cnt=0 are held.
- State machine with 2 states, IDLE and RUN:
  - IDLE -> RUN when enable=1; counters start at 0,0 on the first RUN cycle.
  - RUN -> IDLE when enable=0, immediately and mid-frame allowed. Counters clear to 0.
  - running = (state==RUN), registered.
- Output decode is registered, with a fixed 1-cycle latency from counter to outputs. All outputs are mutually aligned.
  - de = RUN & h<H_ACTIVE & v<V_ACTIVE.
  - x = h_cnt and y = v_cnt when de, else 0.
  - hsync asserted (=SYNC_POL) when H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC. Default range is h=656..751.
  - vsync asserted when V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC, for the whole line. Default range is lines 490..491.
  - line_start = RUN & h==0.
  - frame_start = RUN & h==0 & v==0.
- IDLE outputs: same values as the reset values.
- Lock loss mid-frame: within 2 (sync) + 1 (state) + 1 (output) cycles, all outputs return to idle values. No partial sync pulse is extended beyond that point.
- Relock: a new frame always starts at 0,0, and the first visible output is frame_start.
- Simultaneous h wrap and v wrap: v goes to 0 on the same edge that h goes to 0. No line is skipped or duplicated.
- Arithmetic: all comparisons are unsigned. Parameters are assumed consistent (TOT < 2^width); no runtime check.

Test Plan:
- Reset and unlocked: rst_n=0, then 1, with locked=0 for 1000 cycles -> running=0, de=0, hsync=vsync=1, x=y=0, no strobes.
- Lock start: raise locked -> frame_start first pulses 4 cycles after the locked rise (2 sync + 1 state + 1 output), with de=1, x=0, y=0 on the same cycle. line_start pulses every 800 cycles.
- Line timing: in steady state, per line de=1 for 640 cycles, then 16 cycles low, then hsync=0 for exactly 96 cycles, then 48 cycles of back porch. x runs 0..639.
- Frame timing: frame_start period = 420000 cycles. vsync=0 for exactly 1600 cycles. de covers lines y=0..479. No de during lines 480..524.
- Lock loss mid-frame: drop locked at line 200, pixel 300 -> within 4 cycles running=0, de=0, hsync=vsync=1. Relock -> frame restarts at 0,0 with frame_start.
- Async reset mid-line: pulse rst_n low for 3 ns between edges -> outputs clear immediately, with no clock edge needed. After release and 2 sync cycles, timing restarts at 0,0.
